// File: rtl/hazard_ctl_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard sequencer.
// Control outputs are bundled as one packed struct so each priority level is a single constant.
package hazard_ctl_pkg;
  localparam int REGADDRSIZE = 5;
  localparam logic [REGADDRSIZE-1:0] XZR_ADDR = 5'd31;

  typedef enum logic {
    HZ_STATE_RUN     = 1'b0,
    HZ_STATE_MEMWAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pcwrite;
    logic ifidwrite;
    logic ifid_nop;
    logic idex_nop;
    logic exmem_nop;
    logic pipehold;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam hz_ctl_t CTL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam hz_ctl_t CTL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam hz_ctl_t CTL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // XZR always reads zero, so a load targeting it can never feed a consumer.
  function automatic logic reg_hazard(input logic [REGADDRSIZE-1:0] rd,
                                      input logic [REGADDRSIZE-1:0] rn,
                                      input logic [REGADDRSIZE-1:0] rm,
                                      input logic                   usesrm);
    return (rd != XZR_ADDR) && ((rd == rn) || (usesrm && (rd == rm)));
  endfunction
endpackage

// File: rtl/hazard_ctl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)                   q <= '0;
    else if (inc && (q != '1)) q <= q + 1'b1;
  end
endmodule

// File: rtl/hazard_ctl.sv
// Pipeline sequencer: stalls, flushes and memory-wait holds for the 5-stage LEGv8 core,
// with saturating stall/flush performance counters and a sticky memory-timeout flag.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int MEMTIMEOUT = 64,
  parameter int CNTWIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REGADDRSIZE-1:0] ifid_rn,
  input  logic [REGADDRSIZE-1:0] ifid_rm,
  input  logic                   ifid_usesrm,
  input  logic                   ifid_bcond,
  input  logic                   idex_memread,
  input  logic                   idex_setflags,
  input  logic [REGADDRSIZE-1:0] idex_rd,
  input  logic                   exmem_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pcwrite,
  output logic                   ifidwrite,
  output logic                   ifid_nop,
  output logic                   idex_nop,
  output logic                   exmem_nop,
  output logic                   pipehold,
  output logic                   memfault,
  output logic [CNTWIDTH-1:0]    stallcnt,
  output logic [CNTWIDTH-1:0]    flushcnt
);
  localparam int WW = (MEMTIMEOUT > 2) ? $clog2(MEMTIMEOUT) : 1;
  localparam logic [WW-1:0] WLAST = WW'((MEMTIMEOUT > 0) ? MEMTIMEOUT - 1 : 0);

  hz_state_e     state, nxt;
  logic [WW-1:0] wcnt;
  hz_ctl_t       ctl;
  logic          loaduse, flaguse, flush, fault_set;

  assign loaduse = idex_memread && reg_hazard(idex_rd, ifid_rn, ifid_rm, ifid_usesrm);
  assign flaguse = idex_setflags && ifid_bcond;

  always_comb begin
    ctl       = CTL_RUN;
    nxt       = state;
    flush     = 1'b0;
    fault_set = 1'b0;
    if (state == HZ_STATE_MEMWAIT) begin
      ctl = CTL_HOLD;
      if (dmem_ready) begin
        nxt = HZ_STATE_RUN;
      end else if ((MEMTIMEOUT != 0) && (wcnt == WLAST)) begin
        nxt       = HZ_STATE_RUN;
        fault_set = 1'b1;
      end
    end else if (dmem_req && !dmem_ready) begin
      ctl = CTL_HOLD;
      nxt = HZ_STATE_MEMWAIT;
    end else if (exmem_taken) begin
      // The hazarding instruction in ID is squashed, so its stall is moot.
      ctl   = CTL_FLUSH;
      flush = 1'b1;
    end else if (loaduse || flaguse) begin
      ctl = CTL_STALL;
    end
    if (rst) begin
      ctl   = CTL_RUN;
      flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HZ_STATE_RUN;
      wcnt     <= '0;
      memfault <= 1'b0;
    end else begin
      state    <= nxt;
      memfault <= memfault || fault_set;
      wcnt     <= ((state == HZ_STATE_MEMWAIT) && (nxt == HZ_STATE_MEMWAIT)) ? wcnt + WW'(1) : '0;
    end
  end

  assign pcwrite   = ctl.pcwrite;
  assign ifidwrite = ctl.ifidwrite;
  assign ifid_nop  = ctl.ifid_nop;
  assign idex_nop  = ctl.idex_nop;
  assign exmem_nop = ctl.exmem_nop;
  assign pipehold  = ctl.pipehold;

  sat_counter #(.WIDTH(CNTWIDTH)) u_stallcnt (
    .clk(clk), .rst(rst), .inc(!ctl.pcwrite), .q(stallcnt)
  );

  sat_counter #(.WIDTH(CNTWIDTH)) u_flushcnt (
    .clk(clk), .rst(rst), .inc(flush), .q(flushcnt)
  );
endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed scenarios plus random traffic
// against a cycle-level behavioural model of the sequencing rules.
module tb_hazard_ctl;
  import hazard_ctl_pkg::*;

  logic clk, rst;
  logic [4:0] ifid_rn, ifid_rm, idex_rd;
  logic ifid_usesrm, ifid_bcond, idex_memread, idex_setflags;
  logic exmem_taken, dmem_req, dmem_ready;
  logic pcwrite, ifidwrite, ifid_nop, idex_nop, exmem_nop, pipehold, memfault;
  logic [31:0] stallcnt, flushcnt;
  logic s_pcwrite, s_ifidwrite, s_ifid_nop, s_idex_nop, s_exmem_nop, s_pipehold, s_memfault;
  logic [2:0] s_stallcnt, s_flushcnt;
  logic [5:0] obs;

  int errors = 0;
  int checks = 0;

  // model state
  bit m_wait, m_fault;
  int m_wcycles;
  int unsigned m_stall, m_flush;

  localparam int TO = 8;
  localparam logic [5:0] V_RUN   = 6'b110000;
  localparam logic [5:0] V_HOLD  = 6'b000001;
  localparam logic [5:0] V_FLUSH = 6'b111110;
  localparam logic [5:0] V_STALL = 6'b000100;

  assign obs = {pcwrite, ifidwrite, ifid_nop, idex_nop, exmem_nop, pipehold};

  hazard_ctl #(.MEMTIMEOUT(TO), .CNTWIDTH(32)) dut (
    .clk(clk), .rst(rst), .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_usesrm(ifid_usesrm),
    .ifid_bcond(ifid_bcond), .idex_memread(idex_memread), .idex_setflags(idex_setflags),
    .idex_rd(idex_rd), .exmem_taken(exmem_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pcwrite(pcwrite), .ifidwrite(ifidwrite), .ifid_nop(ifid_nop), .idex_nop(idex_nop),
    .exmem_nop(exmem_nop), .pipehold(pipehold), .memfault(memfault),
    .stallcnt(stallcnt), .flushcnt(flushcnt)
  );

  hazard_ctl #(.MEMTIMEOUT(TO), .CNTWIDTH(3)) dut_s (
    .clk(clk), .rst(rst), .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_usesrm(ifid_usesrm),
    .ifid_bcond(ifid_bcond), .idex_memread(idex_memread), .idex_setflags(idex_setflags),
    .idex_rd(idex_rd), .exmem_taken(exmem_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pcwrite(s_pcwrite), .ifidwrite(s_ifidwrite), .ifid_nop(s_ifid_nop), .idex_nop(s_idex_nop),
    .exmem_nop(s_exmem_nop), .pipehold(s_pipehold), .memfault(s_memfault),
    .stallcnt(s_stallcnt), .flushcnt(s_flushcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector {pcwrite,ifidwrite,ifid_nop,idex_nop,exmem_nop,pipehold}.
  function automatic logic [5:0] model_ctl();
    bit lu, fu;
    if (rst) return V_RUN;
    if (m_wait || (dmem_req && !dmem_ready)) return V_HOLD;
    if (exmem_taken) return V_FLUSH;
    lu = idex_memread && idex_rd != 5'd31 &&
         (idex_rd == ifid_rn || (ifid_usesrm && idex_rd == ifid_rm));
    fu = idex_setflags && ifid_bcond;
    if (lu || fu) return V_STALL;
    return V_RUN;
  endfunction

  function automatic int unsigned sat7(input int unsigned v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic tick();
    logic [5:0] e;
    e = model_ctl();
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_fault = 0; m_wcycles = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[5]) m_stall++;
      if (e == V_FLUSH) m_flush++;
      if (m_wait) begin
        m_wcycles++;
        if (dmem_ready) m_wait = 0;
        else if (m_wcycles == TO) begin m_wait = 0; m_fault = 1; end
      end else if (dmem_req && !dmem_ready) begin
        m_wait = 1; m_wcycles = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    ifid_rn = 0; ifid_rm = 0; ifid_usesrm = 0; ifid_bcond = 0;
    idex_memread = 0; idex_setflags = 0; idex_rd = 0;
    exmem_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    idex_memread = 1; idex_rd = 3; ifid_rn = 3; exmem_taken = 1; #1;
    checks++; if (obs !== V_RUN) begin errors++; $display("FAIL reset_ctl: got %b want %b", obs, V_RUN); end
    tick(); tick(); #1;
    checks++; if (stallcnt !== 0 || flushcnt !== 0) begin errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stallcnt, flushcnt); end
    checks++; if (memfault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", memfault); end
    rst = 0; idle();
  endtask

  task automatic test_loaduse();
    do_reset();
    idex_memread = 1; idex_rd = 3; ifid_rn = 3; #1;
    checks++; if (obs !== V_STALL) begin errors++; $display("FAIL loaduse_ctl: got %b want %b", obs, V_STALL); end
    tick(); idle(); #1;
    checks++; if (obs !== V_RUN) begin errors++; $display("FAIL loaduse_release: got %b want %b", obs, V_RUN); end
    checks++; if (stallcnt !== 1) begin errors++; $display("FAIL loaduse_cnt: got %0d want 1", stallcnt); end
    idex_memread = 1; idex_rd = 31; ifid_rn = 31; ifid_rm = 31; ifid_usesrm = 1; #1;
    checks++; if (obs !== V_RUN) begin errors++; $display("FAIL loaduse_xzr: got %b want %b", obs, V_RUN); end
    tick(); idle();
  endtask

  task automatic test_rm_flag();
    do_reset();
    idex_memread = 1; idex_rd = 5; ifid_rm = 5; ifid_rn = 0; ifid_usesrm = 1; #1;
    checks++; if (obs !== V_STALL) begin errors++; $display("FAIL rm_used: got %b want %b", obs, V_STALL); end
    ifid_usesrm = 0; #1;
    checks++; if (obs !== V_RUN) begin errors++; $display("FAIL rm_unused: got %b want %b", obs, V_RUN); end
    tick(); idle();
    idex_setflags = 1; ifid_bcond = 1; #1;
    checks++; if (obs !== V_STALL) begin errors++; $display("FAIL flaguse: got %b want %b", obs, V_STALL); end
    tick(); idle(); #1;
    checks++; if (obs !== V_RUN || stallcnt !== 1) begin errors++;
      $display("FAIL flaguse_after: got %b cnt %0d want %b cnt 1", obs, stallcnt, V_RUN); end
  endtask

  task automatic test_flush();
    do_reset();
    exmem_taken = 1; idex_memread = 1; idex_rd = 7; ifid_rn = 7; idex_setflags = 1; ifid_bcond = 1; #1;
    checks++; if (obs !== V_FLUSH) begin errors++; $display("FAIL flush_ctl: got %b want %b", obs, V_FLUSH); end
    tick(); idle(); #1;
    checks++; if (flushcnt !== 1 || stallcnt !== 0) begin errors++;
      $display("FAIL flush_cnt: got flush %0d stall %0d want 1 0", flushcnt, stallcnt); end
  endtask

  task automatic test_memwait();
    do_reset();
    dmem_req = 1;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3); exmem_taken = 1; #1;
      checks++; if (obs !== V_HOLD) begin errors++; $display("FAIL memwait_hold%0d: got %b want %b", i, obs, V_HOLD); end
      tick();
    end
    idle(); #1;
    checks++; if (obs !== V_RUN || stallcnt !== 4 || flushcnt !== 0) begin errors++;
      $display("FAIL memwait_exit: got %b stall %0d flush %0d want %b 4 0", obs, stallcnt, flushcnt, V_RUN); end
    dmem_req = 1; dmem_ready = 1; #1;
    checks++; if (obs !== V_RUN) begin errors++; $display("FAIL zero_wait: got %b want %b", obs, V_RUN); end
    tick(); idle(); #1;
    checks++; if (obs !== V_RUN || stallcnt !== 4) begin errors++;
      $display("FAIL zero_wait_after: got %b stall %0d want %b 4", obs, stallcnt, V_RUN); end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    // entry cycle plus TO cycles in MEMWAIT
    for (int i = 0; i <= TO; i++) begin
      #1;
      checks++; if (pipehold !== 1'b1 || memfault !== 1'b0) begin errors++;
        $display("FAIL timeout_hold%0d: got hold %b fault %b want 1 0", i, pipehold, memfault); end
      tick();
    end
    idle(); #1;
    checks++; if (memfault !== 1'b1 || obs !== V_RUN) begin errors++;
      $display("FAIL timeout_fault: got fault %b ctl %b want 1 %b", memfault, obs, V_RUN); end
    tick(); tick(); #1;
    checks++; if (memfault !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", memfault); end
    do_reset(); #1;
    checks++; if (memfault !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", memfault); end
  endtask

  task automatic test_rst_in_memwait();
    do_reset();
    exmem_taken = 1; tick(); idle();
    idex_memread = 1; idex_rd = 2; ifid_rn = 2; tick(); idle();
    dmem_req = 1; tick(); tick();
    rst = 1; #1;
    checks++; if (obs !== V_RUN) begin errors++; $display("FAIL rstwait_ctl: got %b want %b", obs, V_RUN); end
    tick(); rst = 0; idle(); #1;
    checks++; if (obs !== V_RUN || stallcnt !== 0 || flushcnt !== 0 || memfault !== 1'b0) begin errors++;
      $display("FAIL rstwait_after: got %b %0d %0d %b want %b 0 0 0", obs, stallcnt, flushcnt, memfault, V_RUN); end
  endtask

  task automatic test_saturation();
    do_reset();
    idex_memread = 1; idex_rd = 9; ifid_rn = 9;
    for (int i = 0; i < 10; i++) tick();
    idle(); #1;
    checks++; if (s_stallcnt !== 3'd7) begin errors++; $display("FAIL sat_stall3: got %0d want 7", s_stallcnt); end
    checks++; if (stallcnt !== 10) begin errors++; $display("FAIL sat_stall32: got %0d want 10", stallcnt); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      r = $urandom_range(0, 4); idex_rd = (r == 4) ? 5'd31 : 5'(r);
      r = $urandom_range(0, 4); ifid_rn = (r == 4) ? 5'd31 : 5'(r);
      r = $urandom_range(0, 4); ifid_rm = (r == 4) ? 5'd31 : 5'(r);
      ifid_usesrm = 1'($urandom); ifid_bcond = 1'($urandom);
      idex_memread = 1'($urandom); idex_setflags = ($urandom_range(0, 3) == 0);
      exmem_taken = ($urandom_range(0, 3) == 0);
      dmem_req = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 4) == 0);
      #1;
      checks++; if (obs !== model_ctl()) begin errors++;
        $display("FAIL rand_ctl@%0d: got %b want %b", i, obs, model_ctl()); end
      checks++; if (stallcnt !== m_stall || flushcnt !== m_flush || memfault !== m_fault) begin errors++;
        $display("FAIL rand_state@%0d: got %0d %0d %b want %0d %0d %b", i, stallcnt, flushcnt, memfault,
                 m_stall, m_flush, m_fault); end
      checks++; if (s_stallcnt !== 3'(sat7(m_stall)) || s_flushcnt !== 3'(sat7(m_flush))) begin errors++;
        $display("FAIL rand_sat@%0d: got %0d %0d want %0d %0d", i, s_stallcnt, s_flushcnt,
                 sat7(m_stall), sat7(m_flush)); end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    m_wait = 0; m_fault = 0; m_wcycles = 0; m_stall = 0; m_flush = 0;
    idle(); rst = 1;
    test_reset();
    test_loaduse();
    test_rm_flag();
    test_flush();
    test_memwait();
    test_timeout();
    test_rst_in_memwait();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
